main_memory_responder: RTL and testbench

Behavioural main-memory responder for the far side of the L1 cache's memory port. Accepts single requests from the cache (`mem_req`/`mem_write`/`mem_addr`/`mem_write_data`), waits a programmable access latency, then returns a 128-bit line for reads or commits a 32-bit word for writes, and signals completion with a one-cycle `mem_ready` pulse. It also keeps completion counters for the performance-statistics path next to the cache's hit/miss counters.

---
 rtl/main_memory_responder_if.sv | 28 ++
 rtl/main_memory_responder.sv | 117 +++++++++++
 tb/tb_main_memory_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_responder_if.sv
// Memory-port bundle between the L1 cache (master) and the main-memory
// responder (slave).
//   mem_req / mem_write / mem_addr / mem_write_data : request from the cache
//   mem_read_data  : 128-bit line returned on reads (word 0 in [31:0])
//   mem_ready      : one-cycle completion pulse
//   mem_busy       : responder is servicing a request
//   read_count / write_count : completed-access statistics
interface main_memory_responder_if;
    logic         mem_req;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [127:0] mem_read_data;
    logic         mem_ready;
    logic         mem_busy;
    logic [31:0]  read_count;
    logic [31:0]  write_count;

    modport master (
        output mem_req, mem_write, mem_addr, mem_write_data,
        input  mem_read_data, mem_ready, mem_busy, read_count, write_count
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_write_data,
        output mem_read_data, mem_ready, mem_busy, read_count, write_count
    );
endinterface

// File: rtl/main_memory_responder.sv
// Behavioural main memory for the far side of the L1 cache memory port.
// A request accepted in IDLE is held for LATENCY cycles, then a 128-bit line
// is returned (read) or a 32-bit word is committed (write), with a one-cycle
// mem_ready pulse. Requests arriving while busy are dropped, not queued.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : slave side of main_memory_responder_if (request, response,
//            busy flag and completion counters)
// Parameters:
//   ADDR_WORDS : log2 of storage depth in 32-bit words (4..20)
//   LATENCY    : cycles from acceptance to the response edge (1..255)
module main_memory_responder #(
    parameter int unsigned ADDR_WORDS = 12,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    main_memory_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                  state;
    logic [7:0]              cnt;
    logic                    lat_write;
    logic [ADDR_WORDS-1:0]   lat_word;
    logic [31:0]             lat_data;

    // Storage is never reset; contents survive a reset pulse.
    logic [31:0]             storage [0:(1 << ADDR_WORDS) - 1];

    logic [ADDR_WORDS-3:0]   line_idx;
    logic [127:0]            line_data;
    logic                    access;
    logic                    write_en;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_WORDS+2], bus.mem_addr[1:0]};

    assign line_idx = lat_word[ADDR_WORDS-1:2];
    assign access   = (state == WAIT) && (cnt == '0);
    // The !reset term keeps a reset coinciding with the access edge from
    // committing the write while the FSM is being aborted.
    assign write_en = access && lat_write && !reset;
    assign bus.mem_busy = (state != IDLE);

    always_comb begin
        line_data = {storage[{line_idx, 2'd3}],
                     storage[{line_idx, 2'd2}],
                     storage[{line_idx, 2'd1}],
                     storage[{line_idx, 2'd0}]};
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            storage[lat_word] <= lat_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            lat_write         <= 1'b0;
            lat_word          <= '0;
            lat_data          <= '0;
            bus.mem_ready     <= 1'b0;
            bus.mem_read_data <= '0;
            bus.read_count    <= '0;
            bus.write_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.mem_ready <= 1'b0;
                    if (bus.mem_req) begin
                        lat_write <= bus.mem_write;
                        lat_word  <= bus.mem_addr[ADDR_WORDS+1:2];
                        lat_data  <= bus.mem_write_data;
                        cnt       <= CNT_INIT;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (lat_write) begin
                            bus.write_count <= bus.write_count + 32'd1;
                        end else begin
                            bus.mem_read_data <= line_data;
                            bus.read_count    <= bus.read_count + 32'd1;
                        end
                        bus.mem_ready <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: one instance with LATENCY=4
// and one with LATENCY=1. Requests push expected completions into a queue;
// per-instance monitors pop and compare on every mem_ready pulse.
module tb_main_memory_responder;

    localparam int LAT4 = 4;
    localparam int LAT1 = 1;

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
        logic [31:0]  rc;
        logic [31:0]  wc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    exp_t q4[$];
    exp_t q1[$];

    // Reference model of the LATENCY=4 instance (ADDR_WORDS=12).
    logic [31:0]  mem4 [int];
    logic [127:0] last4;
    logic [31:0]  rc4, wc4;
    logic [31:0]  rc1;

    main_memory_responder_if bus4 ();
    main_memory_responder_if bus1 ();

    main_memory_responder #(.ADDR_WORDS(12), .LATENCY(LAT4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    main_memory_responder #(.ADDR_WORDS(12), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word4(input int idx);
        return mem4.exists(idx) ? mem4[idx] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (bus4.mem_ready === 1'b1) begin
            if (q4.size() == 0) begin
                check("spurious_ready4", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("ready_cycle4", 128'(cyc), 128'(e.cyc));
                check("read_data4", bus4.mem_read_data, e.rdata);
                check("read_count4", 128'(bus4.read_count), 128'(e.rc));
                check("write_count4", 128'(bus4.write_count), 128'(e.wc));
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.mem_ready === 1'b1) begin
            if (q1.size() == 0) begin
                check("spurious_ready1", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("ready_cycle1", 128'(cyc), 128'(e.cyc));
                check("read_data1", bus1.mem_read_data, e.rdata);
                check("read_count1", 128'(bus1.read_count), 128'(e.rc));
            end
        end
    end

    // One request on the LATENCY=4 instance; optionally pulses an extra
    // read of 0x80 during WAIT, which must be ignored.
    task automatic issue4(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit pulse_extra);
        exp_t e;
        int   idx;
        int   base;
        @(negedge clk);
        bus4.mem_req        = 1'b1;
        bus4.mem_write      = w;
        bus4.mem_addr       = a;
        bus4.mem_write_data = d;
        idx  = int'((a >> 2) & 32'hFFF);
        base = idx & ~3;
        if (w) begin
            mem4[idx] = d;
            wc4++;
        end else begin
            last4 = {word4(base + 3), word4(base + 2), word4(base + 1), word4(base)};
            rc4++;
        end
        e.cyc   = cyc + 1 + LAT4;
        e.rdata = last4;
        e.rc    = rc4;
        e.wc    = wc4;
        q4.push_back(e);
        @(negedge clk);
        bus4.mem_req        = 1'b0;
        bus4.mem_addr       = 32'hFFFF_FFFF;
        bus4.mem_write_data = 32'h5555_5555;
        check("busy4", 128'(bus4.mem_busy), 128'(1'b1));
        for (int k = 1; k <= LAT4 + 1; k++) begin
            @(negedge clk);
            if (pulse_extra && k == 1) begin
                bus4.mem_req   = 1'b1;
                bus4.mem_write = 1'b0;
                bus4.mem_addr  = 32'h0000_0080;
            end else begin
                bus4.mem_req = 1'b0;
            end
            check("busy4", 128'(bus4.mem_busy), 128'(k <= LAT4));
        end
        bus4.mem_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rc4 = '0; wc4 = '0; last4 = '0; rc1 = '0;
        reset = 1'b1;
        bus4.mem_req = 1'b0; bus4.mem_write = 1'b0; bus4.mem_addr = '0; bus4.mem_write_data = '0;
        bus1.mem_req = 1'b0; bus1.mem_write = 1'b0; bus1.mem_addr = '0; bus1.mem_write_data = '0;
        repeat (3) @(negedge clk);
        check("reset_ready4", 128'(bus4.mem_ready), 128'(1'b0));
        check("reset_busy4", 128'(bus4.mem_busy), 128'(1'b0));
        check("reset_rdata4", bus4.mem_read_data, 128'h0);
        check("reset_rc4", 128'(bus4.read_count), 128'h0);
        check("reset_wc4", 128'(bus4.write_count), 128'h0);
        check("reset_busy1", 128'(bus1.mem_busy), 128'(1'b0));
        reset = 1'b0;
        @(negedge clk);

        // Basic read, zero data, busy for LATENCY+1 cycles.
        issue4(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        // Write then line read: expect 0..._DEADBEEF_00000000.
        issue4(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
        issue4(1'b0, 32'h0000_0040, 32'h0, 1'b0);
        // Aliasing: 0x4000 maps onto word 0.
        issue4(1'b1, 32'h0000_4000, 32'h1111_1111, 1'b0);
        issue4(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        // Extra request during WAIT is dropped.
        issue4(1'b0, 32'h0000_0040, 32'h0, 1'b1);

        // Abort a write with reset two cycles after acceptance.
        @(negedge clk);
        bus4.mem_req        = 1'b1;
        bus4.mem_write      = 1'b1;
        bus4.mem_addr       = 32'h0000_0100;
        bus4.mem_write_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus4.mem_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready4", 128'(bus4.mem_ready), 128'(1'b0));
        check("abort_busy4", 128'(bus4.mem_busy), 128'(1'b0));
        @(negedge clk);
        check("abort_rdata4", bus4.mem_read_data, 128'h0);
        check("abort_rc4", 128'(bus4.read_count), 128'h0);
        check("abort_wc4", 128'(bus4.write_count), 128'h0);
        reset = 1'b0;
        rc4 = '0; wc4 = '0; last4 = '0; rc1 = '0;
        repeat (LAT4 + 2) @(negedge clk);
        issue4(1'b0, 32'h0000_0100, 32'h0, 1'b0);

        // LATENCY=1: mem_req held high across 12 edges -> 4 accepts.
        @(negedge clk);
        bus1.mem_req   = 1'b1;
        bus1.mem_write = 1'b0;
        bus1.mem_addr  = 32'h0000_0020;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            rc1++;
            e.cyc   = cyc + 1 + LAT1 + 3 * k;
            e.rdata = '0;
            e.rc    = rc1;
            e.wc    = '0;
            q1.push_back(e);
        end
        repeat (12) @(negedge clk);
        bus1.mem_req = 1'b0;
        repeat (6) @(negedge clk);
        check("final_rc1", 128'(bus1.read_count), 128'(32'd4));

        repeat (4) @(negedge clk);
        check("pending4", 128'(q4.size()), 128'h0);
        check("pending1", 128'(q1.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
